// File: rtl/pwm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared definitions for the PWM ramp controller:
//   - state_t : controller state encoding (IDLE / LOAD / RAMP)
//   - CNT_W   : default width of the PWM top/compare/counter values
//   - DWELL_W : default width of the per-step dwell count
// No ports (package).
// -----------------------------------------------------------------------------
package pwm_ctrl_pkg;

    localparam int CNT_W   = 16;
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl_if
// Ramp descriptor channel between a host and pwm_ramp_ctrl.
//
// Handshake: a descriptor transfers on any rising clk edge where cfg_valid and
// cfg_ready are both high. The master holds cfg_valid and all cfg_* fields
// stable until that edge; cfg_ready never depends combinationally on
// cfg_valid.
//
// Signals:
//   cfg_valid  master->slave  descriptor present
//   cfg_ready  slave->master  controller can accept a descriptor
//   cfg_top    master->slave  PWM top value            [CNT_W]
//   cfg_start  master->slave  first compare value      [CNT_W]
//   cfg_end    master->slave  final compare value      [CNT_W]
//   cfg_step   master->slave  compare increment        [CNT_W]
//   cfg_dwell  master->slave  periods per step minus 1 [DWELL_W]
//   cfg_pol    master->slave  PWM polarity
//   cfg_mode   master->slave  PWM counting mode
// -----------------------------------------------------------------------------
interface pwm_ramp_ctrl_if #(
    parameter int CNT_W   = pwm_ctrl_pkg::CNT_W,
    parameter int DWELL_W = pwm_ctrl_pkg::DWELL_W
);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_top;
    logic [CNT_W-1:0]   cfg_start;
    logic [CNT_W-1:0]   cfg_end;
    logic [CNT_W-1:0]   cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_pol;
    logic               cfg_mode;

    modport master (
        output cfg_valid, cfg_top, cfg_start, cfg_end, cfg_step,
               cfg_dwell, cfg_pol, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_top, cfg_start, cfg_end, cfg_step,
               cfg_dwell, cfg_pol, cfg_mode,
        output cfg_ready
    );

endinterface

// File: rtl/pwm_wrap_det.sv
// -----------------------------------------------------------------------------
// pwm_wrap_det
// Detects PWM period boundaries from the PWM counter: a boundary is a cycle in
// which the counter reads 0 after having been non-zero in the previous cycle.
// This holds for both edge-aligned and up/down counting.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   clear  in   forces the previous-count register to 0 (used while the PWM
//               is being restarted so the restart is not seen as a boundary)
//   cnt    in   PWM counter            [CNT_W]
//   wrap   out  boundary indication (combinational from register + cnt)
// -----------------------------------------------------------------------------
module pwm_wrap_det #(
    parameter int CNT_W = pwm_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_prev;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_prev <= '0;
        end else begin
            cnt_prev <= cnt;
        end
    end

    assign wrap = (cnt_prev != '0) && (cnt == '0);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Programs and drives a pwm core: accepts a ramp descriptor, restarts the PWM
// for one cycle, then steps the compare value from start to end, one step per
// (dwell+1) PWM periods, only at period boundaries.
//
// Build option: define PWM_RAMP_CTRL_LOOP_EN for triangle "breathing": on
// reaching a target after its dwell the ramp reverses towards the other
// end-point and repeats forever; done never pulses, only abort/rst leave RAMP.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   cfg        slave modport of pwm_ramp_ctrl_if (descriptor handshake)
//   abort      in   stop the ramp, keep current duty, no done
//   pwm_cnt    in   counter from the PWM               [CNT_W]
//   pwm_rst    out  reset to the PWM (registered)
//   pwm_top    out  PWM top value                     [CNT_W]
//   pwm_comp   out  PWM compare value                 [CNT_W]
//   pwm_pol    out  PWM polarity
//   pwm_mode   out  PWM counting mode
//   busy       out  ramp in progress (state != IDLE)
//   done       out  one-cycle pulse when the ramp completes
//   dbg_state  out  current controller state
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl #(
    parameter int CNT_W   = pwm_ctrl_pkg::CNT_W,
    parameter int DWELL_W = pwm_ctrl_pkg::DWELL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_ramp_ctrl_if.slave       cfg,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     pwm_cnt,
    output logic                 pwm_rst,
    output logic [CNT_W-1:0]     pwm_top,
    output logic [CNT_W-1:0]     pwm_comp,
    output logic                 pwm_pol,
    output logic                 pwm_mode,
    output logic                 busy,
    output logic                 done,
    output pwm_ctrl_pkg::state_t dbg_state
);

    import pwm_ctrl_pkg::*;

    state_t             state;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_r;
    logic [CNT_W-1:0]   step_r;
    logic [CNT_W-1:0]   tgt_r;     // end-point currently being ramped towards
    logic               dir_up;
`ifdef PWM_RAMP_CTRL_LOOP_EN
    logic [CNT_W-1:0]   alt_r;     // the other end-point, swapped in on reversal
`endif
    logic               wrap;

    // One step from cur towards tgt, saturating at tgt. The extra bit catches
    // overflow on the way up and underflow on the way down. A zero step jumps
    // straight to the target.
    function automatic logic [CNT_W-1:0] next_comp(
        input logic [CNT_W-1:0] cur,
        input logic [CNT_W-1:0] step,
        input logic [CNT_W-1:0] tgt,
        input logic             up
    );
        logic [CNT_W:0]   sum;
        logic [CNT_W:0]   diff;
        logic [CNT_W-1:0] res;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (step == '0) begin
            res = tgt;
        end else if (up) begin
            res = (sum >= {1'b0, tgt}) ? tgt : sum[CNT_W-1:0];
        end else begin
            res = (diff[CNT_W] || (diff <= {1'b0, tgt})) ? tgt : diff[CNT_W-1:0];
        end
        return res;
    endfunction

    // The PWM counter is stale during LOAD; clearing the history there keeps
    // the restart from being taken as a period boundary.
    pwm_wrap_det #(
        .CNT_W (CNT_W)
    ) u_wrap_det (
        .clk   (clk),
        .rst   (rst),
        .clear (state == LOAD),
        .cnt   (pwm_cnt),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pwm_rst   <= 1'b1;
            pwm_top   <= '0;
            pwm_comp  <= '0;
            pwm_pol   <= 1'b0;
            pwm_mode  <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= '0;
            dwell_r   <= '0;
            step_r    <= '0;
            tgt_r     <= '0;
            dir_up    <= 1'b1;
`ifdef PWM_RAMP_CTRL_LOOP_EN
            alt_r     <= '0;
`endif
        end else begin
            done    <= 1'b0;
            pwm_rst <= 1'b0;
            case (state)
                IDLE: begin
                    // Registering the descriptor here makes every PWM output
                    // valid in the LOAD cycle, alongside pwm_rst.
                    if (cfg.cfg_valid) begin
                        state     <= LOAD;
                        pwm_rst   <= 1'b1;
                        pwm_top   <= cfg.cfg_top;
                        pwm_comp  <= cfg.cfg_start;
                        pwm_pol   <= cfg.cfg_pol;
                        pwm_mode  <= cfg.cfg_mode;
                        dwell_cnt <= cfg.cfg_dwell;
                        dwell_r   <= cfg.cfg_dwell;
                        step_r    <= cfg.cfg_step;
                        tgt_r     <= cfg.cfg_end;
                        dir_up    <= (cfg.cfg_start <= cfg.cfg_end);
`ifdef PWM_RAMP_CTRL_LOOP_EN
                        alt_r     <= cfg.cfg_start;
`endif
                    end
                end
                LOAD: begin
                    state <= abort ? IDLE : RAMP;
                end
                RAMP: begin
                    // abort takes priority over a boundary in the same cycle
                    if (abort) begin
                        state <= IDLE;
                    end else if (wrap) begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end else if (pwm_comp == tgt_r) begin
`ifdef PWM_RAMP_CTRL_LOOP_EN
                            // Reverse and take the first step back in the
                            // same boundary so the peak is held dwell+1
                            // periods like every other level.
                            tgt_r     <= alt_r;
                            alt_r     <= tgt_r;
                            dir_up    <= ~dir_up;
                            pwm_comp  <= next_comp(pwm_comp, step_r, alt_r, ~dir_up);
                            dwell_cnt <= dwell_r;
`else
                            done  <= 1'b1;
                            state <= IDLE;
`endif
                        end else begin
                            pwm_comp  <= next_comp(pwm_comp, step_r, tgt_r, dir_up);
                            dwell_cnt <= dwell_r;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
// Directed bench for pwm_ramp_ctrl with a small edge-aligned PWM counter model
// (counts 0..top, restarts on pwm_rst). A negedge monitor records every
// compare level seen in RAMP and how many cycles it was held; tests compare
// that trace against hand-computed levels and hold lengths.
//
// Hold lengths for top=T, dwell=D: period P=T+1; the first level is held
// (D+1)*P+1 RAMP cycles (the restart period has no preceding non-zero count),
// every later level (D+1)*P cycles.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int CW = 16;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic abort;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    pwm_ramp_ctrl_if #(.CNT_W(CW), .DWELL_W(DW)) cfg_if ();

    logic [CW-1:0] pwm_cnt;
    logic          pwm_rst;
    logic [CW-1:0] pwm_top;
    logic [CW-1:0] pwm_comp;
    logic          pwm_pol;
    logic          pwm_mode;
    logic          busy;
    logic          done;
    state_t        dbg_state;

    pwm_ramp_ctrl #(.CNT_W(CW), .DWELL_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg       (cfg_if),
        .abort     (abort),
        .pwm_cnt   (pwm_cnt),
        .pwm_rst   (pwm_rst),
        .pwm_top   (pwm_top),
        .pwm_comp  (pwm_comp),
        .pwm_pol   (pwm_pol),
        .pwm_mode  (pwm_mode),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // PWM counter model
    always @(posedge clk) begin
        if (pwm_rst) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt >= pwm_top) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [CW-1:0] exp_q[$];
    int            exp_len_q[$];
    logic [CW-1:0] obs_val_q[$];
    int            obs_len_q[$];
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt = done_cnt + 1;
        if (dbg_state == RAMP) begin
            if (obs_val_q.size() == 0 || obs_val_q[obs_val_q.size()-1] != pwm_comp) begin
                obs_val_q.push_back(pwm_comp);
                obs_len_q.push_back(1);
            end else begin
                obs_len_q[obs_len_q.size()-1] = obs_len_q[obs_len_q.size()-1] + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        exp_len_q.delete();
        obs_val_q.delete();
        obs_len_q.delete();
        done_cnt = 0;
    endtask

    // Compares recorded levels/lengths against the expected queues over the
    // entries both sides have.
    task automatic compare_trace(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_val_q.size())
                check_val($sformatf("%s_val%0d", tag, i), obs_val_q[i], exp_q[i]);
        end
        for (int i = 0; i < exp_len_q.size(); i++) begin
            if (i < obs_len_q.size())
                check_val($sformatf("%s_len%0d", tag, i), obs_len_q[i], exp_len_q[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (dbg_state != IDLE && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_timeout"}, (dbg_state != IDLE), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_val("rst_state",     dbg_state, IDLE);
        check_val("rst_cfg_ready", cfg_if.cfg_ready, 1);
        check_val("rst_pwm_rst",   pwm_rst, 1);
        check_val("rst_top",       pwm_top, 0);
        check_val("rst_comp",      pwm_comp, 0);
        check_val("rst_pol",       pwm_pol, 0);
        check_val("rst_mode",      pwm_mode, 0);
        check_val("rst_busy",      busy, 0);
        check_val("rst_done",      done, 0);
        rst = 1'b0;
        tick();
        check_val("rst_release_pwm_rst", pwm_rst, 0);
    endtask

    // Presents a descriptor, checks it is taken, and checks the LOAD cycle.
    task automatic send_cfg(input string tag,
                            input logic [CW-1:0] top, input logic [CW-1:0] start,
                            input logic [CW-1:0] fin, input logic [CW-1:0] step,
                            input logic [DW-1:0] dwell, input logic pol,
                            input logic mode, input bit hold);
        cfg_if.cfg_top   = top;
        cfg_if.cfg_start = start;
        cfg_if.cfg_end   = fin;
        cfg_if.cfg_step  = step;
        cfg_if.cfg_dwell = dwell;
        cfg_if.cfg_pol   = pol;
        cfg_if.cfg_mode  = mode;
        cfg_if.cfg_valid = 1'b1;
        check_val({tag, "_ready"}, cfg_if.cfg_ready, 1);
        tick();
        if (!hold) cfg_if.cfg_valid = 1'b0;
        check_val({tag, "_load_state"}, dbg_state, LOAD);
        check_val({tag, "_load_pwm_rst"}, pwm_rst, 1);
        check_val({tag, "_load_top"}, pwm_top, top);
        check_val({tag, "_load_comp"}, pwm_comp, start);
        check_val({tag, "_load_pol"}, pwm_pol, pol);
        check_val({tag, "_load_mode"}, pwm_mode, mode);
        check_val({tag, "_load_busy"}, busy, 1);
    endtask

    // ---------------- tests ----------------
    initial begin
        int n;
        rst              = 1'b1;
        abort            = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_top   = '0;
        cfg_if.cfg_start = '0;
        cfg_if.cfg_end   = '0;
        cfg_if.cfg_step  = '0;
        cfg_if.cfg_dwell = '0;
        cfg_if.cfg_pol   = 1'b0;
        cfg_if.cfg_mode  = 1'b0;

        do_reset();

`ifndef PWM_RAMP_CTRL_LOOP_EN
        // T1: ramp up 0..3 by 1, top=3, dwell=0 (P=4)
        clear_logs();
        send_cfg("t1", 16'd3, 16'd0, 16'd3, 16'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        wait_idle("t1", 200);
        check_val("t1_done_pulse", done, 1);
        check_val("t1_ready_done", cfg_if.cfg_ready, 1);
        check_val("t1_busy_done", busy, 0);
        check_val("t1_final_comp", pwm_comp, 3);
        exp_q = {16'd0, 16'd1, 16'd2, 16'd3};
        exp_len_q = {5, 4, 4, 4};
        check_val("t1_levels", obs_val_q.size(), 4);
        compare_trace("t1");
        tick();
        check_val("t1_done_low", done, 0);
        check_val("t1_done_count", done_cnt, 1);

        // T2: ramp down 10..1 by 4, top=16, dwell=1 (P=17), saturated last step
        clear_logs();
        send_cfg("t2", 16'd16, 16'd10, 16'd1, 16'd4, 8'd1, 1'b1, 1'b0, 1'b0);
        wait_idle("t2", 400);
        exp_q = {16'd10, 16'd6, 16'd2, 16'd1};
        exp_len_q = {35, 34, 34, 34};
        check_val("t2_levels", obs_val_q.size(), 4);
        compare_trace("t2");
        check_val("t2_done_count", done_cnt, 1);
        check_val("t2_final_comp", pwm_comp, 1);
`endif

        // T3: abort coincident with a boundary while comp=1
        clear_logs();
        send_cfg("t3", 16'd3, 16'd0, 16'd3, 16'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!(dbg_state == RAMP && pwm_cnt == 0 && pwm_comp == 1) && n < 100) begin
            tick();
            n++;
        end
        check_val("t3_reach_boundary", (n < 100), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t3_state_idle", dbg_state, IDLE);
        check_val("t3_busy", busy, 0);
        check_val("t3_comp_held", pwm_comp, 1);
        check_val("t3_no_done", done, 0);
        for (int i = 0; i < 8; i++) tick();
        check_val("t3_comp_still", pwm_comp, 1);
        check_val("t3_done_count", done_cnt, 0);
        exp_q = {16'd0, 16'd1};
        exp_len_q = {5, 4};
        compare_trace("t3");

`ifndef PWM_RAMP_CTRL_LOOP_EN
        // T4: cfg_valid held through a ramp; second descriptor taken on done
        clear_logs();
        send_cfg("t4a", 16'd3, 16'd0, 16'd2, 16'd1, 8'd0, 1'b0, 1'b0, 1'b1);
        cfg_if.cfg_top   = 16'd5;
        cfg_if.cfg_start = 16'd4;
        cfg_if.cfg_end   = 16'd4;
        cfg_if.cfg_step  = 16'd0;
        cfg_if.cfg_dwell = 8'd0;
        cfg_if.cfg_pol   = 1'b1;
        cfg_if.cfg_mode  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_val("t4_mid_state", dbg_state, RAMP);
        check_val("t4_mid_top", pwm_top, 3);
        wait_idle("t4a", 200);
        check_val("t4_done_pulse", done, 1);
        check_val("t4_ready_done", cfg_if.cfg_ready, 1);
        exp_q = {16'd0, 16'd1, 16'd2};
        exp_len_q = {5, 4, 4};
        check_val("t4a_levels", obs_val_q.size(), 3);
        compare_trace("t4a");
        clear_logs();
        tick();
        cfg_if.cfg_valid = 1'b0;
        check_val("t4b_load_state", dbg_state, LOAD);
        check_val("t4b_load_pwm_rst", pwm_rst, 1);
        check_val("t4b_load_top", pwm_top, 5);
        check_val("t4b_load_comp", pwm_comp, 4);
        check_val("t4b_load_pol", pwm_pol, 1);
        check_val("t4b_load_mode", pwm_mode, 1);
        wait_idle("t4b", 200);
        exp_q = {16'd4};
        exp_len_q = {7};
        check_val("t4b_levels", obs_val_q.size(), 1);
        compare_trace("t4b");
        check_val("t4b_done_count", done_cnt, 1);
`endif

        // T5: rst pulse mid-ramp
        clear_logs();
        send_cfg("t5", 16'd3, 16'd0, 16'd3, 16'd1, 8'd0, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (pwm_comp != 2 && n < 100) begin
            tick();
            n++;
        end
        check_val("t5_reach_comp2", (n < 100), 1);
        rst = 1'b1;
        tick();
        check_val("t5_state", dbg_state, IDLE);
        check_val("t5_pwm_rst", pwm_rst, 1);
        check_val("t5_top", pwm_top, 0);
        check_val("t5_comp", pwm_comp, 0);
        check_val("t5_pol", pwm_pol, 0);
        check_val("t5_mode", pwm_mode, 0);
        check_val("t5_busy", busy, 0);
        check_val("t5_ready", cfg_if.cfg_ready, 1);
        rst = 1'b0;
        tick();
        check_val("t5_pwm_rst_release", pwm_rst, 0);
        check_val("t5_pwm_cnt", pwm_cnt, 0);
        check_val("t5_done_count", done_cnt, 0);

`ifdef PWM_RAMP_CTRL_LOOP_EN
        // T6: triangle breathing 0..2..0.. with step 1, never done
        clear_logs();
        send_cfg("t6", 16'd3, 16'd0, 16'd2, 16'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (obs_val_q.size() < 8 && n < 300) begin
            tick();
            n++;
        end
        check_val("t6_enough_levels", (obs_val_q.size() >= 8), 1);
        exp_q = {16'd0, 16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2};
        exp_len_q = {5, 4, 4, 4, 4, 4, 4};
        compare_trace("t6");
        check_val("t6_still_busy", busy, 1);
        check_val("t6_no_done", done_cnt, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("t6_abort_idle", dbg_state, IDLE);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
